// File: rtl/fp_issue_scoreboard.sv
// In-order FP issue stage: buffers decoded instructions, tracks pending register
// writes, and issues the head to a functional block once hazards and the block clear.
module fp_issue_scoreboard #(
  parameter int NUM_BLOCKS = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [2:0]                    instr_block,
  input  logic [3:0]                    instr_src1,
  input  logic [3:0]                    instr_src2,
  input  logic [3:0]                    instr_dest,
  input  logic [15:0]                   dependency_remove,
  input  logic [NUM_BLOCKS-1:0]         block_busy,
  output logic [NUM_BLOCKS-1:0]         issue_valid,
  output logic [3:0]                    issue_src1,
  output logic [3:0]                    issue_src2,
  output logic [3:0]                    issue_dest,
  output logic [15:0]                   busy_regs,
  output logic                          stall,
  output logic                          illegal_op,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, EVAL} state_t;

  typedef struct packed {
    logic [2:0] blk;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
  } entry_t;

  // Handshake: an instruction is accepted on a rising clk edge where
  // instr_valid and instr_ready are both high; instr_ready is simply !full.
  state_t                state, next_state;
  entry_t                mem [FIFO_DEPTH];
  entry_t                head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [15:0]           eff_busy, set_mask;
  logic [NUM_BLOCKS-1:0] blk_onehot;
  logic                  push, pop, hazard, legal, blk_busy, do_issue, do_drop;

  assign instr_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push        = instr_valid & instr_ready;
  assign pop         = do_issue | do_drop;
  assign head        = mem[rd_ptr];
  // A clear arriving this cycle is already visible to this cycle's hazard check.
  assign eff_busy    = busy_regs & ~dependency_remove;
  assign hazard      = eff_busy[head.src1] | eff_busy[head.src2] | eff_busy[head.dest];
  assign set_mask    = do_issue ? (16'h0001 << head.dest) : 16'h0000;

  always_comb begin
    legal      = 1'b0;
    blk_busy   = 1'b0;
    blk_onehot = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (head.blk == 3'(i)) begin
        legal         = 1'b1;
        blk_busy      = block_busy[i];
        blk_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    do_issue   = 1'b0;
    do_drop    = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (push) next_state = EVAL;
      end
      EVAL: begin
        if (fifo_count != '0) begin
          if (!legal)                    do_drop  = 1'b1;
          else if (!hazard && !blk_busy) do_issue = 1'b1;
          else                           stall    = 1'b1;
        end
        if (!push && (fifo_count == '0 || (pop && fifo_count == CW'(1))))
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr_block, instr_src1, instr_src2, instr_dest};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      busy_regs   <= '0;
      issue_valid <= '0;
      issue_src1  <= '0;
      issue_src2  <= '0;
      issue_dest  <= '0;
      illegal_op  <= 1'b0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // Set after clear, so a register released and re-claimed in one cycle stays busy.
      busy_regs   <= eff_busy | set_mask;
      issue_valid <= do_issue ? blk_onehot : '0;
      illegal_op  <= do_drop;
      if (do_issue) begin
        issue_src1 <= head.src1;
        issue_src2 <= head.src2;
        issue_dest <= head.dest;
      end
    end
  end

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Directed bench for fp_issue_scoreboard: basic issue, RAW stall, full FIFO,
// same-cycle clear/set, illegal block drop and asynchronous reset.
module tb_fp_issue_scoreboard;

  localparam int NB = 6;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_block;
  logic [3:0]    instr_src1, instr_src2, instr_dest;
  logic [15:0]   dependency_remove;
  logic [NB-1:0] block_busy;
  logic [NB-1:0] issue_valid;
  logic [3:0]    issue_src1, issue_src2, issue_dest;
  logic [15:0]   busy_regs;
  logic          stall;
  logic          illegal_op;
  logic [2:0]    fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  fp_issue_scoreboard #(.NUM_BLOCKS(NB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_block(instr_block), .instr_src1(instr_src1),
    .instr_src2(instr_src2), .instr_dest(instr_dest),
    .dependency_remove(dependency_remove), .block_busy(block_busy),
    .issue_valid(issue_valid), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_dest(issue_dest),
    .busy_regs(busy_regs), .stall(stall), .illegal_op(illegal_op),
    .fifo_count(fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_block = '0; instr_src1 = '0; instr_src2 = '0; instr_dest = '0;
    dependency_remove = '0;
    block_busy = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // driver
  task automatic push(input logic [2:0] b, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] d);
    instr_block = b; instr_src1 = s1; instr_src2 = s2; instr_dest = d;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (busy_regs !== 16'h0000) begin n_fail++; $display("FAIL reset_busy: got %h expected 0000", busy_regs); end
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL reset_issue: got %b expected 000000", issue_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal_op); end
  endtask

  task automatic test_basic_issue;
    do_reset;
    push(3'd2, 4'd1, 4'd2, 4'd3);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", fifo_count); end
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL basic_early: got %b expected 000000", issue_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall: got %b expected 0", stall); end
    tick;
    n_checks++; if (issue_valid !== 6'b000100) begin n_fail++; $display("FAIL basic_issue: got %b expected 000100", issue_valid); end
    n_checks++; if ({issue_src1, issue_src2, issue_dest} !== 12'h123) begin n_fail++; $display("FAIL basic_fields: got %h expected 123", {issue_src1, issue_src2, issue_dest}); end
    n_checks++; if (busy_regs !== 16'h0008) begin n_fail++; $display("FAIL basic_busy: got %h expected 0008", busy_regs); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL basic_count_after: got %0d expected 0", fifo_count); end
    dependency_remove = 16'h0002;
    tick;
    dependency_remove = 16'h0000;
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL basic_pulse: got %b expected 000000", issue_valid); end
    n_checks++; if (issue_dest !== 4'd3) begin n_fail++; $display("FAIL basic_hold: got %0d expected 3", issue_dest); end
    n_checks++; if (busy_regs !== 16'h0008) begin n_fail++; $display("FAIL basic_ignore_clear: got %h expected 0008", busy_regs); end
  endtask

  task automatic test_raw;
    do_reset;
    push(3'd1, 4'd1, 4'd2, 4'd5);
    tick;
    n_checks++; if (busy_regs !== 16'h0020) begin n_fail++; $display("FAIL raw_busy_first: got %h expected 0020", busy_regs); end
    push(3'd2, 4'd5, 4'd1, 4'd6);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b expected 1", stall); end
    tick;
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL raw_no_issue: got %b expected 000000", issue_valid); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL raw_count: got %0d expected 1", fifo_count); end
    dependency_remove = 16'h0020;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_clear_visible: got %b expected 0", stall); end
    tick;
    dependency_remove = 16'h0000;
    n_checks++; if (issue_valid !== 6'b000100) begin n_fail++; $display("FAIL raw_issue: got %b expected 000100", issue_valid); end
    n_checks++; if (issue_dest !== 4'd6) begin n_fail++; $display("FAIL raw_dest: got %0d expected 6", issue_dest); end
    n_checks++; if (busy_regs !== 16'h0040) begin n_fail++; $display("FAIL raw_busy_after: got %h expected 0040", busy_regs); end
  endtask

  task automatic test_full_fifo;
    logic [15:0] exp_busy;
    do_reset;
    block_busy = 6'b111111;
    for (int i = 0; i < 4; i++) push(3'd0, 4'(i), 4'(i), 4'(8 + i));
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", instr_ready); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b expected 1", stall); end
    push(3'd1, 4'd15, 4'd15, 4'd15);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_no_push: got %0d expected 4", fifo_count); end
    block_busy = 6'b111110;
    exp_busy = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp_busy[8 + i] = 1'b1;
      n_checks++; if (issue_valid !== 6'b000001) begin n_fail++; $display("FAIL drain_issue_%0d: got %b expected 000001", i, issue_valid); end
      n_checks++; if (issue_dest !== 4'(8 + i)) begin n_fail++; $display("FAIL drain_dest_%0d: got %0d expected %0d", i, issue_dest, 8 + i); end
      n_checks++; if (fifo_count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count_%0d: got %0d expected %0d", i, fifo_count, 3 - i); end
      n_checks++; if (busy_regs !== exp_busy) begin n_fail++; $display("FAIL drain_busy_%0d: got %h expected %h", i, busy_regs, exp_busy); end
    end
    tick;
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL drain_idle: got %b expected 000000", issue_valid); end
    block_busy = '0;
  endtask

  task automatic test_same_cycle_clear_set;
    do_reset;
    push(3'd3, 4'd1, 4'd2, 4'd7);
    tick;
    n_checks++; if (busy_regs !== 16'h0080) begin n_fail++; $display("FAIL waw_busy_first: got %h expected 0080", busy_regs); end
    push(3'd4, 4'd1, 4'd2, 4'd7);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", stall); end
    dependency_remove = 16'h0080;
    tick;
    dependency_remove = 16'h0000;
    n_checks++; if (issue_valid !== 6'b010000) begin n_fail++; $display("FAIL waw_issue: got %b expected 010000", issue_valid); end
    n_checks++; if (busy_regs !== 16'h0080) begin n_fail++; $display("FAIL waw_set_wins: got %h expected 0080", busy_regs); end
    push(3'd5, 4'd9, 4'd9, 4'd9);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL self_dep_stall: got %b expected 0", stall); end
    tick;
    n_checks++; if (issue_valid !== 6'b100000) begin n_fail++; $display("FAIL self_dep_issue: got %b expected 100000", issue_valid); end
    n_checks++; if (busy_regs !== 16'h0280) begin n_fail++; $display("FAIL self_dep_busy: got %h expected 0280", busy_regs); end
  endtask

  task automatic test_illegal;
    do_reset;
    push(3'd7, 4'd1, 4'd2, 4'd3);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL illegal_stall: got %b expected 0", stall); end
    tick;
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 1", illegal_op); end
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL illegal_no_issue: got %b expected 000000", issue_valid); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL illegal_count: got %0d expected 0", fifo_count); end
    n_checks++; if (busy_regs !== 16'h0000) begin n_fail++; $display("FAIL illegal_busy: got %h expected 0000", busy_regs); end
    tick;
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_single: got %b expected 0", illegal_op); end
  endtask

  task automatic test_async_reset;
    do_reset;
    for (int i = 0; i < 4; i++) push(3'(i), 4'd0, 4'd0, 4'(4 + i));
    tick;
    block_busy = 6'b111111;
    for (int i = 0; i < 3; i++) push(3'd0, 4'd1, 4'd1, 4'(8 + i));
    n_checks++; if (busy_regs !== 16'h00F0) begin n_fail++; $display("FAIL pre_reset_busy: got %h expected 00f0", busy_regs); end
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", fifo_count); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", fifo_count); end
    n_checks++; if (busy_regs !== 16'h0000) begin n_fail++; $display("FAIL async_busy: got %h expected 0000", busy_regs); end
    n_checks++; if ({issue_valid, issue_src1, issue_src2, issue_dest} !== 18'h0) begin n_fail++; $display("FAIL async_issue: got %h expected 0", {issue_valid, issue_src1, issue_src2, issue_dest}); end
    n_checks++; if ({stall, illegal_op} !== 2'b00) begin n_fail++; $display("FAIL async_flags: got %b expected 00", {stall, illegal_op}); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b expected 1", instr_ready); end
    block_busy = '0;
    tick;
    rst = 1'b0;
    tick;
    n_checks++; if (issue_valid !== 6'b000000) begin n_fail++; $display("FAIL post_reset_issue: got %b expected 000000", issue_valid); end
  endtask

  initial begin
    test_reset;
    test_basic_issue;
    test_raw;
    test_full_fifo;
    test_same_cycle_clear_set;
    test_illegal;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_issue_scoreboard.md
Name: fp_issue_scoreboard

Overview:
Issue stage that consumes the 16-bit dependency_remove vector produced by the result-collection logic. It tracks which of the 16 FP registers have a pending write. It buffers incoming decoded instructions in a small in-order FIFO and issues the head instruction to one of NUM_BLOCKS functional blocks once its RAW/WAW hazards are clear and the target block is idle.

Parameters:
NUM_BLOCKS, 6, number of functional blocks; opcode values 0..NUM_BLOCKS-1 are legal
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
instr_valid  input  1  decoded instruction present
instr_ready  output  1  buffer can accept; equals !full
instr_block  input  3  target functional block index
instr_src1  input  4  source register A
instr_src2  input  4  source register B
instr_dest  input  4  destination register
dependency_remove  input  16  one-hot-per-register clear mask from result collection
block_busy  input  NUM_BLOCKS  per-block busy flag
issue_valid  output  NUM_BLOCKS  one-hot, single-cycle issue strobe to the selected block
issue_src1  output  4  issued source A
issue_src2  output  4  issued source B
issue_dest  output  4  issued destination
busy_regs  output  16  current scoreboard (pending-write) vector
stall  output  1  head present but not issuable this cycle
illegal_op  output  1  single-cycle pulse when an illegal-block instruction is dropped
fifo_count  output  clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_count=0, busy_regs=0, issue_valid=0, issue_src1/src2/dest=0, stall=0, illegal_op=0, FSM=IDLE. Reset mid-operation discards all buffered instructions and pending busy bits.
- Push: on rising clk when instr_valid & instr_ready. No push when full. Push and pop in the same cycle leave the count unchanged.
- Effective busy (combinational): eff = busy_regs & ~dependency_remove. A clear arriving in a cycle is visible to that cycle's hazard check.
- Hazard for head: eff[src1] | eff[src2] | eff[dest].
- Issuable: head present & !hazard & !block_busy[blk] & blk<NUM_BLOCKS.
- FSM:
  - IDLE: FIFO empty, stall=0. Go to EVAL when fifo_count becomes nonzero.
  - EVAL: evaluates the head each cycle.
    - Issuable: pop; register issue_valid[blk]=1 and issue_src1/src2/dest for exactly one cycle at the next edge.
    - blk>=NUM_BLOCKS: pop without issue; illegal_op pulses 1 cycle at the next edge.
    - Otherwise: stall=1 (combinational), no pop.
    - Return to IDLE when the FIFO becomes empty after the pop.
- Latency: an instruction pushed at edge N is evaluated in cycle N+1. With no hazard, issue_valid is high during cycle N+2. Back-to-back issues are possible every cycle.
- Scoreboard update per edge: busy_next = (busy_regs & ~dependency_remove) | (issue ? onehot(dest) : 0). If the same register is cleared and set in one cycle, set wins.
- Self-dependency (src==dest) does not stall unless that register is already busy.
- The head is never bypassed; issue is strictly in order.
- issue_src/dest hold their last value when issue_valid=0.
- dependency_remove bits for registers not busy are ignored.

Test Plan:
- Reset then push {blk=2, s1=1, s2=2, d=3}, all idle -> issue_valid=6'b000100 two cycles after push, issue_dest=3, busy_regs=16'h0008 in the same cycle.
- RAW: issue d=5, then push s1=5 -> stall=1, no issue. Drive dependency_remove=16'h0020 for one cycle -> second instruction issues at the next edge; busy_regs bit5 cleared and then set to the new dest.
- Fill 4 instructions while block_busy=6'b111111 -> instr_ready=0, fifo_count=4, stall=1. Release block 0 -> in-order issues and count decrements to 0.
- Same-cycle clear and set: busy bit7 set, head d=7 with WAW blocked, dependency_remove=16'h0080 -> head issues and busy_regs[7] remains 1.
- Push blk=7 -> illegal_op pulses once, no issue_valid bit set, fifo_count returns to 0.
- Assert rst while 3 entries are buffered and busy_regs=16'h00F0 -> all outputs 0 immediately, before the next clk edge.
